macc1d_dot_seq: RTL
===================

MACC1D_DOT_SEQ -- requirements
Module: macc1d_dot_seq

Interface
REQ-001 SHALL have parameter IN_IW, default 4, integer bits of m_in/x_in (signed, sign bit included).
REQ-002 SHALL have parameter IN_QW, default 12, fractional bits of m_in/x_in; IN_W = IN_IW+IN_QW.
REQ-003 SHALL have parameter ACC_IW, default 12, integer bits of bias_in/y_out.
REQ-004 SHALL have parameter ACC_QW, default 24, fractional bits of bias_in/y_out; ACC_W = ACC_IW+ACC_QW.
REQ-005 SHALL have parameter MAX_LEN, default 256, maximum beats per vector.
REQ-006 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_in  input  1  reset, asynchronous, active-high.
REQ-008 in_valid  input  1  beat (m_in, x_in, in_last, bias_in) valid.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 m_in, x_in  input  IN_W each  signed fixed-point operands.
REQ-011 in_last  input  1  final beat of the current vector.
REQ-012 bias_in  input  ACC_W  signed bias; sampled only on the first beat of a vector.
REQ-013 out_valid  output  1  y_out holds a finished dot product.
REQ-014 out_ready  input  1  downstream accepts y_out.
REQ-015 y_out  output  ACC_W  bias + sum(m*x), saturated.
REQ-016 overflow_out  output  1  saturation occurred in the vector currently presented; valid with out_valid.
REQ-017 len_err_out  output  1  vector was force-terminated at MAX_LEN; valid with out_valid.

Function
REQ-018 A beat SHALL transfer when in_valid && in_ready; an output SHALL transfer when out_valid && out_ready.
REQ-019 Stage 1 SHALL register prod = m_in*x_in (full 2*IN_W signed), plus first/last flags, on each accepted beat.
REQ-020 Stage 2 SHALL add the registered product into the accumulator: acc = (first ? bias : acc) + prod, with prod sign-extended to ACC_W.
REQ-021 Stage 2 addition SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set sticky overflow for the vector; a saturated value is the base for later beats.
REQ-022 FSM states SHALL be ACCUM (accepting beats) and HOLD (result presented); reset enters ACCUM.
REQ-023 ACCUM->HOLD when stage 2 consumes a last-flagged product; HOLD->ACCUM on output transfer.
REQ-024 Latency SHALL be 2 cycles: last beat accepted at edge t gives out_valid=1 after edge t+2.
REQ-025 in_ready SHALL be 0 in HOLD and while a last-flagged product occupies stage 1; otherwise 1.
REQ-026 y_out, overflow_out and len_err_out SHALL stay stable while out_valid && !out_ready.
REQ-027 Gaps in in_valid between beats SHALL NOT alter the result.
REQ-028 The beat count SHALL reach MAX_LEN and that beat SHALL be treated as last (len_err set) when in_last is not asserted.
REQ-029 The first beat after an output transfer (or reset) SHALL start a new vector with a fresh bias, a fresh count and cleared flags.

Reset
REQ-030 rst_in SHALL immediately clear out_valid, y_out, overflow_out, len_err_out, the accumulator, the stage-1 valid, and the beat count to 0, and set state to ACCUM.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_in deasserts; a partial vector in progress when reset is asserted SHALL be discarded.

Structure
REQ-032 Format helpers (width functions, saturation limits) SHALL live in the shared fixed-point package.
REQ-033 Elaboration SHALL fail unless ACC_QW == 2*IN_QW and ACC_IW >= 2*IN_IW.
REQ-034 The stage-2 multiply-add SHALL be a single instance of macc1d_fplib (m = product path, b = accumulator or bias), with saturation external.

Verification (defaults; 1.0 in = 0x1000, 1.0 acc = 0x1000000)
REQ-035 Single beat: m=1.0, x=2.0, bias=0.5, last -> y=2.5 (0x2800000) two cycles later; overflow=0, len_err=0.
REQ-036 Four beats: m=0.5, x=1,2,3,4, bias=-1.0 -> y=4.0 (0x4000000).
REQ-037 Hold out_ready=0 for 5 cycles -> y stable, in_ready=0, no beats lost; next vector is accepted the cycle after the output handshake.
REQ-038 40 beats m=x=-8.0 (0x8000), bias 0 -> y=0x7FFFFFFFF, overflow=1; the following vector (1.0*1.0) -> 1.0, overflow=0.
REQ-039 Assert rst_in after 2 of 4 beats -> all outputs 0 at once; a new 1-beat vector gives the correct result.
REQ-040 MAX_LEN=4, 6 beats sent without last -> first result after beat 4 with len_err=1; beats 5-6 form a new vector.

Source files
------------

// File: rtl/macc1d_dot_seq_pkg.sv
// Shared fixed-point helpers for the dot-product MAC: format widths,
// saturation limits and the sequencer state type.
package macc1d_dot_seq_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic int fx_width(input int iw, input int qw);
        return iw + qw;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Limits are built in 64 bits; callers keep the low w bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/macc1d_fplib.sv
// Stage-2 add of a full-precision product into a bias/accumulator base.
// The sum carries one guard bit so the caller can detect and saturate.
module macc1d_fplib
    import macc1d_dot_seq_pkg::*;
#(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 36
)
(
    input  logic signed [PROD_W-1:0] i_m,
    input  logic signed [ACC_W-1:0]  i_b,
    output logic signed [ACC_W:0]    o_sum
);

    logic signed [ACC_W:0] w_m_ext;
    logic signed [ACC_W:0] w_b_ext;

    assign w_m_ext = {{(ACC_W + 1 - PROD_W){i_m[PROD_W-1]}}, i_m};
    assign w_b_ext = {i_b[ACC_W-1], i_b};
    assign o_sum   = w_m_ext + w_b_ext;

endmodule

// File: rtl/macc1d_dot_seq.sv
// Streaming signed fixed-point dot product: bias + sum(m*x) with saturation,
// a two-stage multiply/accumulate pipeline and a held, handshaken result.
module macc1d_dot_seq
    import macc1d_dot_seq_pkg::*;
#(
    parameter int IN_IW   = 4,
    parameter int IN_QW   = 12,
    parameter int ACC_IW  = 12,
    parameter int ACC_QW  = 24,
    parameter int MAX_LEN = 256
)
(
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [IN_IW+IN_QW-1:0]     m_in,
    input  logic signed [IN_IW+IN_QW-1:0]     x_in,
    input  logic                              in_last,
    input  logic signed [ACC_IW+ACC_QW-1:0]   bias_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [ACC_IW+ACC_QW-1:0]   y_out,
    output logic                              overflow_out,
    output logic                              len_err_out
);

    localparam int IN_W   = fx_width(IN_IW, IN_QW);
    localparam int ACC_W  = fx_width(ACC_IW, ACC_QW);
    localparam int PROD_W = 2 * IN_W;
    localparam int CNT_W  = cnt_width(MAX_LEN);
    localparam logic [63:0]      SAT_MAX64 = sat_max(ACC_W);
    localparam logic [63:0]      SAT_MIN64 = sat_min(ACC_W);
    localparam logic [ACC_W-1:0] ACC_MAX   = SAT_MAX64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] ACC_MIN   = SAT_MIN64[ACC_W-1:0];
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_LEN - 1);

    generate
        if (ACC_QW != 2 * IN_QW || ACC_IW < 2 * IN_IW || ACC_W > 64) begin : g_bad_fmt
            $error("macc1d_dot_seq: accumulator format cannot hold the product");
        end
    endgenerate

    state_t                    r_state;
    logic                      r_s1_valid;
    logic                      r_s1_first;
    logic                      r_s1_last;
    logic                      r_s1_len_err;
    logic signed [PROD_W-1:0]  r_prod;
    logic signed [ACC_W-1:0]   r_s1_bias;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_ovf;
    logic                      r_len_err;
    logic                      r_fin;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_out_valid;
    logic signed [ACC_W-1:0]   r_y;
    logic                      r_ovf_out;
    logic                      r_len_out;

    logic                      w_accept;
    logic                      w_first;
    logic                      w_cnt_hit;
    logic                      w_last;
    logic                      w_out_xfer;
    logic signed [ACC_W-1:0]   w_base;
    logic signed [ACC_W:0]     w_sum;
    logic                      w_sat_hi;
    logic                      w_sat_lo;
    logic signed [ACC_W-1:0]   w_sat;

    // A last-flagged product in stage 1 stalls input until the result is handed off.
    assign in_ready   = (r_state == ST_ACCUM) && !(r_s1_valid && r_s1_last);
    assign w_accept   = in_valid && in_ready;
    assign w_first    = (r_cnt == '0);
    assign w_cnt_hit  = (r_cnt == CNT_LAST);
    assign w_last     = in_last || w_cnt_hit;
    assign w_out_xfer = r_out_valid && out_ready;

    assign w_base = r_s1_first ? r_s1_bias : r_acc;

    macc1d_fplib #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_fplib (
        .i_m   (r_prod),
        .i_b   (w_base),
        .o_sum (w_sum)
    );

    assign w_sat_hi = !w_sum[ACC_W] &&  w_sum[ACC_W-1];
    assign w_sat_lo =  w_sum[ACC_W] && !w_sum[ACC_W-1];
    assign w_sat    = w_sat_hi ? ACC_MAX : (w_sat_lo ? ACC_MIN : w_sum[ACC_W-1:0]);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= ST_ACCUM;
            r_s1_valid   <= 1'b0;
            r_s1_first   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_len_err <= 1'b0;
            r_prod       <= '0;
            r_s1_bias    <= '0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            r_len_err    <= 1'b0;
            r_fin        <= 1'b0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_y          <= '0;
            r_ovf_out    <= 1'b0;
            r_len_out    <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_prod       <= PROD_W'(m_in) * PROD_W'(x_in);
                r_s1_first   <= w_first;
                r_s1_last    <= w_last;
                r_s1_len_err <= w_cnt_hit && !in_last;
                if (w_first) begin
                    r_s1_bias <= bias_in;
                end
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end

            r_fin <= 1'b0;
            if (r_s1_valid) begin
                r_acc     <= w_sat;
                r_ovf     <= (r_s1_first ? 1'b0 : r_ovf) | w_sat_hi | w_sat_lo;
                r_len_err <= r_s1_len_err;
                if (r_s1_last) begin
                    r_fin   <= 1'b1;
                    r_state <= ST_HOLD;
                end
            end

            // Result register adds the second cycle of latency and stays frozen in HOLD.
            if (r_fin) begin
                r_out_valid <= 1'b1;
                r_y         <= r_acc;
                r_ovf_out   <= r_ovf;
                r_len_out   <= r_len_err;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
                r_state     <= ST_ACCUM;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign y_out        = r_y;
    assign overflow_out = r_ovf_out;
    assign len_err_out  = r_len_out;

endmodule
